// File: rtl/l1_sequencer.sv
// L1 signalling sequencer: stages one packet, burst-loads it into the
// parameter store, and streams it to the packer by rotating the store.
module l1_sequencer #(
   parameter int L1_LEN = 67,
   parameter int CW     = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] CFG_DATA,
   input  logic       CFG_VALID,
   input  logic       CFG_START,
   output logic       CFG_READY,
   input  logic       L1_REQ,
   input  logic [7:0] L1_DATA_OUT,
   output logic [7:0] L1_DATA_IN,
   output logic       L1_LOAD,
   output logic       L1_SHIFT,
   output logic [7:0] OUT_DATA,
   output logic       OUT_VALID,
   input  logic       OUT_READY,
   output logic       OUT_LAST,
   output logic       L1_VALID,
   output logic       REQ_DROP,
   output logic       SYNC_ERR
);

   localparam int AW = $clog2(L1_LEN);
   localparam logic [CW-1:0] LAST = CW'(L1_LEN - 1);

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      LOAD,
      SEND
   } state_e;

   state_e        state_q;
   logic [7:0]    stage_q [L1_LEN];
   logic [CW-1:0] wr_cnt_q;
   logic [CW-1:0] rd_addr_q;
   logic [CW-1:0] tx_cnt_q;
   logic [CW-1:0] rd_nxt;
   logic [AW-1:0] wr_idx;
   logic [AW-1:0] rd_idx;
   logic [7:0]    din_q;
   logic          pending_q;
   logic          req_q;
   logic          valid_q;
   logic          load_q;
   logic          rdy_en_q;
   logic          drop_q;
   logic          serr_q;
   logic          accept;
   logic          wr_en;
   logic          pend_set;
   logic          shift;

   assign CFG_READY  = rdy_en_q & ~pending_q & (state_q != LOAD);
   assign accept     = CFG_VALID & CFG_READY;
   assign wr_en      = accept & (CFG_START | (wr_cnt_q != '0));
   assign wr_idx     = CFG_START ? '0 : wr_cnt_q[AW-1:0];
   assign pend_set   = accept & ~CFG_START & (wr_cnt_q == LAST);
   assign rd_nxt     = rd_addr_q + CW'(1);
   assign rd_idx     = (state_q == PREP) ? '0 : rd_nxt[AW-1:0];

   assign OUT_VALID  = (state_q == SEND);
   assign OUT_DATA   = OUT_VALID ? L1_DATA_OUT : '0;
   assign shift      = OUT_VALID & OUT_READY;
   assign L1_SHIFT   = shift;
   assign OUT_LAST   = OUT_VALID & (tx_cnt_q == LAST);
   assign L1_LOAD    = load_q;
   assign L1_DATA_IN = din_q;
   assign L1_VALID   = valid_q;
   assign REQ_DROP   = drop_q;
   assign SYNC_ERR   = serr_q;

   // Staging buffer storage; contents need no reset.
   always_ff @(posedge CLK) begin
      if (wr_en) stage_q[wr_idx] <= CFG_DATA;
   end

   // Staging byte counter, resync detection and ready enable.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_cnt_q <= '0;
         serr_q   <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         rdy_en_q <= 1'b1;
         serr_q   <= accept & CFG_START & (wr_cnt_q != '0);
         if (accept) begin
            if (CFG_START)
               wr_cnt_q <= CW'(1);
            else if (wr_cnt_q == LAST)
               wr_cnt_q <= '0;
            else if (wr_cnt_q != '0)
               wr_cnt_q <= wr_cnt_q + CW'(1);
         end
      end
   end

   // Main controller: request latch, burst load and rotating send.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         tx_cnt_q  <= '0;
         pending_q <= 1'b0;
         req_q     <= 1'b0;
         valid_q   <= 1'b0;
         load_q    <= 1'b0;
         din_q     <= '0;
         drop_q    <= 1'b0;
      end else begin
         drop_q <= 1'b0;
         if (pend_set) pending_q <= 1'b1;
         if (L1_REQ) begin
            if ((state_q == SEND) || req_q || (!valid_q && !pending_q))
               drop_q <= 1'b1;
            else
               req_q <= 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (pending_q) begin
                  state_q <= PREP;
               end else if (req_q && valid_q) begin
                  state_q  <= SEND;
                  req_q    <= 1'b0;
                  tx_cnt_q <= '0;
               end
            end
            PREP: begin
               rd_addr_q <= '0;
               din_q     <= stage_q[rd_idx];
               load_q    <= 1'b1;
               state_q   <= LOAD;
            end
            LOAD: begin
               if (rd_addr_q == LAST) begin
                  load_q    <= 1'b0;
                  din_q     <= '0;
                  pending_q <= 1'b0;
                  valid_q   <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  rd_addr_q <= rd_nxt;
                  din_q     <= stage_q[rd_idx];
               end
            end
            SEND: begin
               if (shift) begin
                  if (tx_cnt_q == LAST) begin
                     tx_cnt_q <= '0;
                     state_q  <= IDLE;
                  end else begin
                     tx_cnt_q <= tx_cnt_q + CW'(1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_sequencer.sv
// Directed bench for l1_sequencer with a rotating parameter-store model
// and queue scoreboards for load bytes and output bytes.
module tb_l1_sequencer;

   localparam int N = 67;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] CFG_DATA = '0;
   logic       CFG_VALID = 1'b0;
   logic       CFG_START = 1'b0;
   logic       CFG_READY;
   logic       L1_REQ = 1'b0;
   logic [7:0] L1_DATA_OUT;
   logic [7:0] L1_DATA_IN;
   logic       L1_LOAD;
   logic       L1_SHIFT;
   logic [7:0] OUT_DATA;
   logic       OUT_VALID;
   logic       OUT_READY = 1'b1;
   logic       OUT_LAST;
   logic       L1_VALID;
   logic       REQ_DROP;
   logic       SYNC_ERR;

   int checks = 0;
   int errors = 0;
   int drops = 0;
   int serrs = 0;
   int run = 0;
   logic [7:0] ldq[$];
   logic [8:0] outq[$];
   logic [8:0] e;
   logic [7:0] prev_out = '0;
   logic       prev_stall = 1'b0;
   logic [7:0] mem [N];

   l1_sequencer #(.L1_LEN(N), .CW(8)) dut (
      .CLK(CLK), .RST(RST),
      .CFG_DATA(CFG_DATA), .CFG_VALID(CFG_VALID),
      .CFG_START(CFG_START), .CFG_READY(CFG_READY),
      .L1_REQ(L1_REQ), .L1_DATA_OUT(L1_DATA_OUT),
      .L1_DATA_IN(L1_DATA_IN), .L1_LOAD(L1_LOAD),
      .L1_SHIFT(L1_SHIFT), .OUT_DATA(OUT_DATA),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OUT_LAST(OUT_LAST), .L1_VALID(L1_VALID),
      .REQ_DROP(REQ_DROP), .SYNC_ERR(SYNC_ERR)
   );

   always #5 CLK = ~CLK;

   // Parameter store: load shifts bytes in at the tail, shift rotates.
   always @(posedge CLK) begin
      if (L1_LOAD || L1_SHIFT) begin
         for (int i = 0; i < N - 1; i++) mem[i] <= mem[i+1];
         mem[N-1] <= L1_LOAD ? L1_DATA_IN : mem[0];
      end
   end
   assign L1_DATA_OUT = mem[0];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: pop scoreboards as load and output bytes appear.
   always @(negedge CLK) begin
      if (!RST) begin
         run = 0;
         prev_stall = 1'b0;
      end else begin
         if (L1_LOAD) begin
            chk("load_excl", {30'd0, L1_SHIFT, OUT_VALID}, 0);
            if (ldq.size() == 0) chk("load_underflow", 1, 0);
            else chk("load_data", L1_DATA_IN, ldq.pop_front());
            run++;
         end else if (run != 0) begin
            chk("load_run", run, N);
            run = 0;
         end
         if (OUT_VALID && OUT_READY) begin
            chk("shift_on_xfer", L1_SHIFT, 1);
            if (outq.size() == 0) chk("out_underflow", 1, 0);
            else begin
               e = outq.pop_front();
               chk("out_data", OUT_DATA, e[7:0]);
               chk("out_last", OUT_LAST, e[8]);
            end
         end else if (OUT_VALID) begin
            chk("stall_noshift", L1_SHIFT, 0);
            if (prev_stall) chk("stall_hold", OUT_DATA, prev_out);
         end
         prev_stall = OUT_VALID && !OUT_READY;
         prev_out = OUT_DATA;
         if (REQ_DROP) drops++;
         if (SYNC_ERR) serrs++;
      end
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic feed(input logic [7:0] d, input logic st);
      int t = 0;
      repeat ($urandom_range(0, 2)) tick();
      CFG_DATA = d;
      CFG_START = st;
      CFG_VALID = 1'b1;
      while (!CFG_READY && t < 3000) begin
         tick();
         t++;
      end
      if (t >= 3000) chk("cfg_ready_timeout", 0, 1);
      tick();
      CFG_VALID = 1'b0;
      CFG_START = 1'b0;
   endtask

   task automatic pkt(input logic [7:0] base);
      for (int i = 0; i < N; i++) ldq.push_back(8'(base + i));
      for (int i = 0; i < N; i++) feed(8'(base + i), i == 0);
   endtask

   task automatic wait_load;
      int t = 0;
      while ((ldq.size() != 0 || L1_LOAD || !L1_VALID) && t < 3000) begin
         tick();
         t++;
      end
      if (t >= 3000) chk("load_timeout", 0, 1);
   endtask

   task automatic req(input logic [7:0] base);
      for (int i = 0; i < N; i++)
         outq.push_back({i == N - 1, 8'(base + i)});
      L1_REQ = 1'b1;
      tick();
      L1_REQ = 1'b0;
   endtask

   task automatic wait_send;
      int t = 0;
      while ((outq.size() != 0 || OUT_VALID) && t < 3000) begin
         tick();
         t++;
      end
      if (t >= 3000) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_ov;
      int t = 0;
      while (!OUT_VALID && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) chk("ovalid_timeout", 0, 1);
   endtask

   initial begin
      int s0;
      int t;
      #2 RST = 1'b0;
      tick();
      tick();
      chk("rst_cfg_ready", CFG_READY, 0);
      chk("rst_load", L1_LOAD, 0);
      chk("rst_ovalid", OUT_VALID, 0);
      chk("rst_l1valid", L1_VALID, 0);
      chk("rst_din", L1_DATA_IN, 0);
      RST = 1'b1;
      tick();
      chk("rdy_after_rst", CFG_READY, 1);

      // Request with nothing stored is dropped.
      L1_REQ = 1'b1;
      tick();
      L1_REQ = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("drop_no_ovalid", OUT_VALID, 0);
      end
      chk("drop_count", drops, 1);

      // First load with gaps.
      pkt(8'h00);
      wait_load();
      chk("l1_valid_set", L1_VALID, 1);
      chk("num_t2_frames", mem[16], 8'h10);
      chk("store_head", mem[0], 8'h00);

      // Two back-to-back sends; store realigns each time.
      req(8'h00);
      wait_send();
      chk("realign1", mem[0], 8'h00);
      req(8'h00);
      wait_send();
      chk("realign2", mem[0], 8'h00);

      // Ready toggled 1-0-1 during send.
      req(8'h00);
      wait_ov();
      repeat (5) tick();
      OUT_READY = 1'b0;
      repeat (4) tick();
      OUT_READY = 1'b1;
      wait_send();

      // New packet staged while a send is stalled.
      req(8'h00);
      wait_ov();
      OUT_READY = 1'b0;
      pkt(8'h80);
      repeat (3) tick();
      chk("no_load_in_send", L1_LOAD, 0);
      chk("send_held", OUT_VALID, 1);
      OUT_READY = 1'b1;
      wait_send();
      wait_load();
      req(8'h80);
      wait_send();

      // Mid-packet restart raises a sync error.
      s0 = serrs;
      for (int i = 0; i < 20; i++) feed(8'(8'h20 + i), i == 0);
      pkt(8'h50);
      wait_load();
      tick();
      chk("sync_err_count", serrs - s0, 1);
      req(8'h50);
      wait_send();

      // Reset during load cycle 30.
      pkt(8'h10);
      t = 0;
      while (!L1_LOAD && t < 500) begin
         tick();
         t++;
      end
      if (t >= 500) chk("abort_load_timeout", 0, 1);
      repeat (30) tick();
      #2 RST = 1'b0;
      #1;
      chk("abort_load", L1_LOAD, 0);
      chk("abort_din", L1_DATA_IN, 0);
      chk("abort_l1valid", L1_VALID, 0);
      chk("abort_cfg_ready", CFG_READY, 0);
      chk("abort_ovalid", OUT_VALID, 0);
      ldq.delete();
      tick();
      tick();
      RST = 1'b1;
      tick();
      tick();
      chk("post_abort_l1valid", L1_VALID, 0);
      pkt(8'h30);
      wait_load();
      chk("reload_valid", L1_VALID, 1);
      req(8'h30);
      wait_send();
      chk("final_head", mem[0], 8'h30);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
